// File: rtl/cpu_pkg.sv
// Shared constants and grant-owner encoding for the CPU top-level data-memory path.
package cpu_pkg;

    localparam logic [2:0] FUNCT3_WORD      = 3'b010;
    localparam int         DEFAULT_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_HOST
    } gnt_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU priority with a bounded host wait.
// Optional DMEM_ARB_BOOT_LOAD_EN: host owns the port while reset is high.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [2:0]       cpu_funct3,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [WIDTH-1:0] host_addr,
    input  logic [WIDTH-1:0] host_wdata,
    output logic             host_gnt,
    output logic             host_rvalid,
    output logic [WIDTH-1:0] host_rdata,
    output logic             mem_we,
    output logic [2:0]       mem_funct3,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    gnt_e             owner;
    logic             host_rd;

    always_comb begin
        owner      = GNT_NONE;
        mem_we     = 1'b0;
        mem_funct3 = FUNCT3_WORD;
        mem_addr   = '0;
        mem_wdata  = '0;

        if (reset) begin
`ifdef DMEM_ARB_BOOT_LOAD_EN
            if (host_req) owner = GNT_HOST;
`else
            owner = GNT_NONE;
`endif
        end else if (host_req && (!cpu_req || wait_cnt >= WAIT_LIM)) begin
            owner = GNT_HOST;
        end else if (cpu_req) begin
            owner = GNT_CPU;
        end

        case (owner)
            GNT_CPU: begin
                mem_we     = cpu_we;
                mem_funct3 = cpu_funct3;
                mem_addr   = cpu_addr;
                mem_wdata  = cpu_wdata;
            end
            GNT_HOST: begin
                mem_we    = host_we;
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
            end
            default: ;
        endcase

        host_gnt  = (owner == GNT_HOST);
        // The core is frozen in reset, so never report a stall to it then.
        cpu_stall = cpu_req && (owner != GNT_CPU) && !reset;
        host_rd   = host_gnt && !host_we;
    end

    assign cpu_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
`ifdef DMEM_ARB_BOOT_LOAD_EN
            host_rvalid <= host_rd;
            host_rdata  <= host_rd ? mem_rdata : '0;
`else
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
`endif
        end else begin
            if (host_gnt || !host_req)
                wait_cnt <= '0;
            else if (wait_cnt < WAIT_LIM)
                wait_cnt <= wait_cnt + 1'b1;
            host_rvalid <= host_rd;
            if (host_rd)
                host_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed plan steps plus random traffic against a reference model.
module tb_dmem_arbiter;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [2:0]  cpu_funct3;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        host_req, host_we;
    logic [31:0] host_addr, host_wdata;
    logic        host_gnt, host_rvalid;
    logic [31:0] host_rdata;
    logic        mem_we;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    dmem_arbiter #(.WIDTH(32), .MAX_WAIT(MW), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_funct3(cpu_funct3),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Environment memory: asynchronous read, word write on the rising edge.
    logic [31:0] mem [64];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    // Reference model state
    logic [31:0] ref_mem [64];
    int          m_wait;
    logic        m_rv;
    logic [31:0] m_rd;
    logic        e_hg, e_cg;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check combinational outputs for the inputs currently applied.
    task automatic comb_chk();
        logic [31:0] ea, ed;
        logic        ew;
        logic [2:0]  ef;
        #1;
        e_hg = !reset && host_req && (!cpu_req || m_wait >= MW);
        e_cg = !reset && cpu_req && !e_hg;
        ew = 1'b0; ef = 3'b010; ea = '0; ed = '0;
        if (e_hg) begin
            ew = host_we; ea = host_addr; ed = host_wdata;
        end else if (e_cg) begin
            ew = cpu_we; ef = cpu_funct3; ea = cpu_addr; ed = cpu_wdata;
        end
        chk("host_gnt", {31'b0, host_gnt}, {31'b0, e_hg});
        chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, !reset && cpu_req && !e_cg});
        chk("mem_we", {31'b0, mem_we}, {31'b0, ew});
        chk("mem_funct3", {29'b0, mem_funct3}, {29'b0, ef});
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        if (e_cg && !cpu_we) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:2]]);
    endtask

    // Advance one clock, update the model, check registered outputs.
    task automatic clk_chk();
        @(posedge clk);
        if (reset) begin
            m_wait = 0; m_rv = 1'b0; m_rd = '0;
        end else begin
            m_rv = e_hg && !host_we;
            if (e_hg && !host_we) m_rd = ref_mem[host_addr[7:2]];
            if (e_hg && host_we) ref_mem[host_addr[7:2]] = host_wdata;
            if (e_cg && cpu_we) ref_mem[cpu_addr[7:2]] = cpu_wdata;
            if (host_req && !e_hg) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
            else m_wait = 0;
        end
        #1;
        chk("host_rvalid", {31'b0, host_rvalid}, {31'b0, m_rv});
        chk("host_rdata", host_rdata, m_rd);
        @(negedge clk);
    endtask

    task automatic cyc();
        comb_chk();
        clk_chk();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'h1000_0000 + i;
            ref_mem[i] = 32'h1000_0000 + i;
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        m_wait = 0; m_rv = 1'b0; m_rd = '0;

        // Reset with both sides requesting writes: nothing may reach memory.
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_funct3 = 3'b010; cpu_addr = 32'h8; cpu_wdata = 32'h5555_0000;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h0; host_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            comb_chk();
            chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
            clk_chk();
        end
        chk("rst_no_write", mem[0], 32'h1000_0000);

        // CPU load only
        reset = 1'b0; host_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h40;
        comb_chk();
        chk("cpu_only_addr", mem_addr, 32'h40);
        chk("cpu_only_stall", {31'b0, cpu_stall}, 32'd0);
        clk_chk();

        // Host read only
        cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 32'h10;
        comb_chk();
        chk("host_rd_gnt", {31'b0, host_gnt}, 32'd1);
        clk_chk();
        chk("host_rd_data", host_rdata, 32'hDEADBEEF);
        chk("host_rd_valid", {31'b0, host_rvalid}, 32'd1);

        // Continuous contention: host forced on the fifth cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h44;
        for (int i = 0; i < 6; i++) begin
            comb_chk();
            chk("starve_gnt", {31'b0, host_gnt}, (i == 4) ? 32'd1 : 32'd0);
            chk("starve_stall", {31'b0, cpu_stall}, (i == 4) ? 32'd1 : 32'd0);
            clk_chk();
        end

        // Host write with CPU idle, then CPU word load of same address
        cpu_req = 1'b0; host_req = 1'b1; host_we = 1'b1; host_addr = 32'h20; host_wdata = 32'h12345678;
        comb_chk();
        chk("hw_funct3", {29'b0, mem_funct3}, 32'd2);
        clk_chk();
        host_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_funct3 = 3'b010; cpu_addr = 32'h20;
        comb_chk();
        chk("cpu_lw_back", cpu_rdata, 32'h12345678);
        clk_chk();

        // Reset mid-wait: counter restarts
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h10;
        for (int i = 0; i < 3; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            comb_chk();
            chk("post_rst_gnt", {31'b0, host_gnt}, (i == 4) ? 32'd1 : 32'd0);
            clk_chk();
        end
        host_req = 1'b0;

        // Random traffic; host holds each request until granted
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            cpu_req = $urandom_range(0, 1);
            cpu_we = $urandom_range(0, 1);
            cpu_funct3 = cpu_we ? 3'b010 : 3'($urandom_range(0, 7));
            cpu_addr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
            cpu_wdata = $urandom;
            if (!host_req && $urandom_range(0, 2) == 0) begin
                host_req = 1'b1;
                host_we = $urandom_range(0, 1);
                host_addr = {24'b0, 6'($urandom_range(0, 63)), 2'b00};
                host_wdata = $urandom;
            end
            comb_chk();
            clk_chk();
            if (e_hg) host_req = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between two requesters: the CPU load/store path and an external host (loader/debug) port.
- Sits between the CPU core, the external access pins and data_memory at the CPU top level.
- Replaces the ad-hoc reset-time write mux with an explicit grant/stall handshake and a starvation bound.
- CPU has priority; a saturating wait counter forces a host grant after MAX_WAIT denied cycles.

Parameters:
- WIDTH, 32, data and address width.
- MAX_WAIT, 4, consecutive denied host-request cycles before the host is forced a grant (1..15).
- CNT_W, 4, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU requests a memory access this cycle.
- cpu_we  input  1  CPU access is a store.
- cpu_funct3  input  3  CPU access size/sign (load/store funct3).
- cpu_addr  input  WIDTH  CPU byte address.
- cpu_wdata  input  WIDTH  CPU store data.
- cpu_rdata  output  WIDTH  load data, combinational from mem_rdata.
- cpu_stall  output  1  high when cpu_req is high and the CPU is not granted.
- host_req  input  1  host requests an access; held until host_gnt.
- host_we  input  1  host access is a write.
- host_addr  input  WIDTH  host byte address.
- host_wdata  input  WIDTH  host write data.
- host_gnt  output  1  host access performed this cycle.
- host_rvalid  output  1  registered; host read data valid, one cycle after a granted host read.
- host_rdata  output  WIDTH  registered host read data.
- mem_we  output  1  to data_memory write enable.
- mem_funct3  output  3  to data_memory size select.
- mem_addr  output  WIDTH  to data_memory address.
- mem_wdata  output  WIDTH  to data_memory write data.
- mem_rdata  input  WIDTH  from data_memory, asynchronous read.

Behaviour:
- Grant decision is combinational each cycle from the inputs and wait_cnt.
  - Rule: host_gnt = host_req && (!cpu_req || wait_cnt >= MAX_WAIT); cpu_gnt = cpu_req && !host_gnt.
- Memory mux:
  - Granted requester drives mem_addr, mem_wdata and mem_we.
  - mem_funct3 = cpu_funct3 on a CPU grant; 3'b010 (word) on a host grant.
  - No grant: mem_we = 0, mem_addr = 0, mem_wdata = 0, mem_funct3 = 3'b010.
- Outputs:
  - cpu_rdata = mem_rdata at all times; meaningful only when cpu_gnt && !cpu_we.
  - cpu_stall = cpu_req && !cpu_gnt.
- wait_cnt:
  - Cleared when host_gnt or !host_req.
  - Incremented when host_req && !host_gnt, saturating at MAX_WAIT.
  - Forced grant therefore occurs on the (MAX_WAIT+1)-th consecutive requesting cycle.
- host_rvalid and host_rdata:
  - host_rvalid <= host_gnt && !host_we.
  - host_rdata <= mem_rdata when that term is true; otherwise host_rdata holds.
- Simultaneous requests below the threshold: CPU wins, host waits, no stall to the CPU.
- Host write and CPU read to the same address in one cycle cannot occur; only one access per cycle.
- Reset, synchronous:
  - wait_cnt = 0, host_rvalid = 0, host_rdata = 0.
  - While reset is high the combinational outputs are forced: cpu_stall = 0, host_gnt = 0, mem_we = 0.
  - Exception: BOOT_LOAD_EN, see Optional Feature.
- Reset asserted mid-wait: the counter clears; the host must keep host_req high after reset and restarts from wait_cnt = 0.

Optional Feature:
- Macro: DMEM_ARB_BOOT_LOAD_EN.
- Defined:
  - While reset is high, the host owns the port exclusively: host_gnt = host_req and cpu requests are ignored.
  - Host writes and reads complete normally; host_rvalid is still produced.
  - This supports program/data preload while the core is held in reset.
- Undefined: reset blocks all memory accesses, as described under Behaviour.

Decomposition:
- Shared package cpu_pkg holds:
  - FUNCT3_WORD = 3'b010.
  - Default MAX_WAIT.
  - An enum for grant owner: GNT_NONE, GNT_CPU, GNT_HOST.
- No sub-module is needed; the wait counter is inline.
- The mux and grant logic remain a single always_comb block.

Test Plan:
- Reset held for 2 cycles, then cpu_req=1 and host_req=0: no stall; mem_addr follows cpu_addr (e.g. 0x40); mem_we = cpu_we; host_rvalid = 0.
- Host read only, host_addr=0x10 with memory holding 0xDEADBEEF: host_gnt=1 the same cycle; host_rvalid=1 and host_rdata=0xDEADBEEF the next cycle.
- cpu_req and host_req held high continuously with MAX_WAIT=4:
  - Cycles 1-4: CPU granted, cpu_stall=0.
  - Cycle 5: host_gnt=1 and cpu_stall=1.
  - Cycle 6: CPU granted again.
- Host write 0x12345678 to 0x20 while the CPU is idle, then CPU lw from 0x20: cpu_rdata=0x12345678; mem_funct3 was 3'b010 during the host write.
- Reset asserted while wait_cnt=3: the counter clears; after release the host waits a full 4 cycles again under continuous CPU traffic.
- With DMEM_ARB_BOOT_LOAD_EN, reset high, host writes 0xA5A5A5A5 to 0x0 while cpu_req=1: the write lands, cpu_stall=0; after reset the CPU reads back 0xA5A5A5A5. Without the macro, mem_we stays 0 during reset.
